pixel_ctrl: RTL and testbench
=============================

PIXEL_CTRL -- requirements
Module: pixel_ctrl

Interface
REQ-001 Parameter c_erase, default 5, ERASE phase length in clk cycles (>=1).
REQ-002 Parameter c_expose, default 255, EXPOSE phase length in clk cycles (>=1).
REQ-003 Parameter c_convert, default 255, CONVERT phase length in clk cycles (1..256).
REQ-004 Parameter c_read, default 5, READ phase length in clk cycles (>=2).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request one full pixel cycle; sampled only in IDLE.
REQ-008 erase  output  1  pixel erase strobe, high throughout ERASE.
REQ-009 expose  output  1  integration enable (pixel transfer), high throughout EXPOSE.
REQ-010 convert  output  1  ADC ramp enable, high throughout CONVERT.
REQ-011 read  output  1  pixel readout enable, high throughout READ.
REQ-012 data  inout  8  shared pixel bus, driven by this block only in CONVERT, else high-Z.
REQ-013 pixOut  output  8  registered pixel sample captured in READ.
REQ-014 pixValid  output  1  one-cycle strobe when pixOut is updated.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, ERASE, EXPOSE, CONVERT, READ, one-hot or binary, exactly one active.
REQ-017 IDLE -> ERASE on the clock edge where start=1; start ignored in all other states.
REQ-018 ERASE -> EXPOSE -> CONVERT -> READ -> IDLE, each state lasting exactly its parameter count of cycles.
REQ-019 8-bit phase counter cleared on every state entry, incremented each cycle, transition when counter = length-1.
REQ-020 erase/expose/convert/read are registered decodes of state: high in exactly the cycles the FSM is in that state, no glitches.
REQ-021 In CONVERT, data SHALL carry the 8-bit Gray code of the phase counter (value 0 on first CONVERT cycle).
REQ-022 data SHALL be high-Z on the same edge CONVERT is left; no cycle in which both this block and a pixel drive the bus.
REQ-023 In READ, data sampled on the last READ cycle (counter = c_read-1) into pixOut, pixValid high the following cycle for exactly one cycle.
REQ-024 pixOut holds its value until the next capture.
REQ-025 Gray counter wrap: c_convert=256 SHALL end at code 8'h80 (Gray of 255) without wrapping to 0.
REQ-026 start held high continuously SHALL produce back-to-back frames with exactly one IDLE cycle between READ and ERASE.
REQ-027 busy SHALL go high the cycle after start is accepted and low on the cycle the FSM re-enters IDLE.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, counter 0, pixOut 8'h00, pixValid 0, all strobes 0, data high-Z.
REQ-029 Reset mid-frame (any state) SHALL abort immediately; no pixValid issued for the aborted frame.
REQ-030 start asserted while reset=0 SHALL be ignored; first acceptance on the first edge with reset=1.

Structure
REQ-031 State encoding enum, Gray conversion function and default phase lengths SHALL live in a shared package pixel_pkg.
REQ-032 Gray counter SHALL be a separate sub-module gray_counter (8-bit, clear, enable, Gray output).
REQ-033 Tri-state bus driver SHALL be a continuous assignment in pixel_ctrl, not in the sub-module.

Verification
REQ-034 Reset released, start pulse 1 cycle -> erase 5, expose 255, convert 255, read 5 cycles in order, busy high 520 cycles.
REQ-035 CONVERT with c_convert=256 -> data sequence 00,01,03,02,06,... ends 80, then high-Z next cycle.
REQ-036 Bench drives data=8'hA5 during READ -> pixOut=8'hA5, pixValid single pulse one cycle after last READ cycle.
REQ-037 reset=0 asserted in cycle 10 of CONVERT -> next edge all strobes 0, data high-Z, no pixValid, pixOut unchanged 8'h00 if no prior frame.
REQ-038 start held high for 3 frames -> three pixValid pulses, exactly one IDLE cycle between frames.
REQ-039 Bus contention check: bench monitor flags any cycle where data is driven by both sides -> zero violations over all scenarios.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel controller: bus width, default phase
// lengths, FSM state encoding and the binary-to-Gray helper.
package pixel_pkg;

    localparam int unsigned PIX_W = 8;

    localparam int unsigned C_ERASE_DEF   = 5;
    localparam int unsigned C_EXPOSE_DEF  = 255;
    localparam int unsigned C_CONVERT_DEF = 255;
    localparam int unsigned C_READ_DEF    = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    // Reflected binary Gray code of b.
    function automatic logic [PIX_W-1:0] bin2gray(input logic [PIX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_counter.sv
// 8-bit phase counter with synchronous clear and count enable.
// Ports: clk; clear (sync, wins over en); en; count = binary value;
// gray = registered Gray code of count (always bin2gray(count)).
module gray_counter
    import pixel_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [PIX_W-1:0] count,
    output logic [PIX_W-1:0] gray
);

    logic [PIX_W-1:0] count_inc;

    assign count_inc = count + PIX_W'(1);

    // Gray is registered from the incremented value so it tracks count exactly.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
            gray  <= '0;
        end else if (en) begin
            count <= count_inc;
            gray  <= bin2gray(count_inc);
        end
    end

endmodule

// File: rtl/pixel_ctrl.sv
// Pixel sequencer: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> IDLE.
// Ports: clk; reset (sync, active-low); start (frame request, IDLE only);
// erase/expose/convert/read = registered phase strobes; data = shared bus,
// driven with the Gray ramp code during CONVERT, else high-Z; pixOut =
// sample captured on the last READ cycle; pixValid = one-cycle strobe the
// cycle after capture; busy = high outside IDLE.
module pixel_ctrl
    import pixel_pkg::*;
#(
    parameter int unsigned c_erase   = C_ERASE_DEF,
    parameter int unsigned c_expose  = C_EXPOSE_DEF,
    parameter int unsigned c_convert = C_CONVERT_DEF,
    parameter int unsigned c_read    = C_READ_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read,
    inout  wire  [PIX_W-1:0] data,
    output logic [PIX_W-1:0] pixOut,
    output logic             pixValid,
    output logic             busy
);

    localparam logic [PIX_W-1:0] ERASE_LAST   = PIX_W'(c_erase - 1);
    localparam logic [PIX_W-1:0] EXPOSE_LAST  = PIX_W'(c_expose - 1);
    localparam logic [PIX_W-1:0] CONVERT_LAST = PIX_W'(c_convert - 1);
    localparam logic [PIX_W-1:0] READ_LAST    = PIX_W'(c_read - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PIX_W-1:0] cnt;
    logic [PIX_W-1:0] gray;
    logic             cnt_clr;
    logic             capture;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; each phase ends when its counter reaches length-1.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            ST_IDLE:    if (start)               state_nxt = ST_ERASE;
            ST_ERASE:   if (cnt == ERASE_LAST)   state_nxt = ST_EXPOSE;
            ST_EXPOSE:  if (cnt == EXPOSE_LAST)  state_nxt = ST_CONVERT;
            ST_CONVERT: if (cnt == CONVERT_LAST) state_nxt = ST_READ;
            ST_READ: begin
                if (cnt == READ_LAST) begin
                    state_nxt = ST_IDLE;
                    capture   = 1'b1;
                end
            end
            default:                             state_nxt = ST_IDLE;
        endcase
        if (!reset) begin
            state_nxt = ST_IDLE;
            capture   = 1'b0;
        end
    end

    // Counter restarts on every state entry, so a 256-cycle CONVERT stops at 255.
    assign cnt_clr = !reset || (state_nxt != state);

    gray_counter u_gray_counter (
        .clk   (clk),
        .clear (cnt_clr),
        .en    (state != ST_IDLE),
        .count (cnt),
        .gray  (gray)
    );

    // Strobes decoded from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            erase   <= 1'b0;
            expose  <= 1'b0;
            convert <= 1'b0;
            read    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            erase   <= (state_nxt == ST_ERASE);
            expose  <= (state_nxt == ST_EXPOSE);
            convert <= (state_nxt == ST_CONVERT);
            read    <= (state_nxt == ST_READ);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    // Pixel capture on the last READ cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pixOut   <= '0;
            pixValid <= 1'b0;
        end else begin
            pixValid <= capture;
            if (capture) begin
                pixOut <= data;
            end
        end
    end

    // Bus released on the same edge that convert drops.
    assign data = convert ? gray : {PIX_W{1'bz}};

endmodule

// File: tb/tb_pixel_ctrl.sv
// Directed bench for pixel_ctrl: reset behaviour, a full default frame,
// mid-CONVERT abort, back-to-back frames and a 256-cycle Gray ramp.
module tb_pixel_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic start_a;
    logic start_b;
    logic sel;
    logic tb_en;
    logic [7:0] tb_val;

    wire  [7:0] data_a;
    wire  [7:0] data_b;
    logic erase_a, expose_a, convert_a, read_a, valid_a, busy_a;
    logic erase_b, expose_b, convert_b, read_b, valid_b, busy_b;
    logic [7:0] pix_a, pix_b;

    int checks = 0;
    int failures = 0;
    int contention = 0;

    always #5 clk = ~clk;

    assign data_a = (tb_en && !sel) ? tb_val : 8'bzzzzzzzz;
    assign data_b = (tb_en &&  sel) ? tb_val : 8'bzzzzzzzz;

    pixel_ctrl u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .erase(erase_a), .expose(expose_a), .convert(convert_a), .read(read_a),
        .data(data_a), .pixOut(pix_a), .pixValid(valid_a), .busy(busy_a)
    );

    pixel_ctrl #(.c_convert(256)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .erase(erase_b), .expose(expose_b), .convert(convert_b), .read(read_b),
        .data(data_b), .pixOut(pix_b), .pixValid(valid_b), .busy(busy_b)
    );

    logic [3:0] obs_strb;
    logic [7:0] obs_data;
    logic [7:0] obs_pix;
    logic       obs_valid;
    logic       obs_busy;

    always_comb begin
        obs_strb  = sel ? {read_b, convert_b, expose_b, erase_b}
                        : {read_a, convert_a, expose_a, erase_a};
        obs_data  = sel ? data_b  : data_a;
        obs_pix   = sel ? pix_b   : pix_a;
        obs_valid = sel ? valid_b : valid_a;
        obs_busy  = sel ? busy_b  : busy_a;
    end

    // Bench and DUT must never drive the same bus in the same cycle.
    always @(negedge clk) begin
        if (tb_en && ((!sel && convert_a) || (sel && convert_b))) contention++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gray8(input int k);
        return 8'(k ^ (k >> 1));
    endfunction

    // Walk one phase p (0 erase .. 3 read) of len cycles; return early at stop_at.
    task automatic run_phase(input int p, input int len, input logic [7:0] pix, input int stop_at);
        for (int k = 0; k < len; k++) begin
            if (k == stop_at) return;
            chk("strobes", 32'(obs_strb), 32'(4'b0001 << p));
            chk("busy", 32'(obs_busy), 32'd1);
            chk("pixvalid_in_frame", 32'(obs_valid), 32'd0);
            if (p == 2) chk("gray", 32'(obs_data), 32'(gray8(k)));
            else if (tb_en) chk("bus_probe", 32'(obs_data), 32'(tb_val));
            if (p == 1 && k == len - 1) tb_en = 1'b0;
            if (p == 3) begin
                tb_en  = 1'b1;
                tb_val = (k == len - 1) ? pix : ~pix;
            end
            step();
        end
    endtask

    // Full frame starting at the first ERASE cycle, ending in the IDLE cycle.
    task automatic run_frame(input logic [7:0] pix, input int lconv);
        run_phase(0, 5, pix, -1);
        run_phase(1, 255, pix, -1);
        run_phase(2, lconv, pix, -1);
        run_phase(3, 5, pix, -1);
        chk("end_strobes", 32'(obs_strb), 32'd0);
        chk("end_busy", 32'(obs_busy), 32'd0);
        chk("end_pixvalid", 32'(obs_valid), 32'd1);
        chk("end_pixout", 32'(obs_pix), 32'(pix));
        chk("end_bus_probe", 32'(obs_data), 32'(pix));
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b1; start_b = 1'b0; sel = 1'b0;
        tb_en = 1'b1; tb_val = 8'h3C;

        // Reset with start high: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_strobes", 32'(obs_strb), 32'd0);
            chk("rst_busy", 32'(obs_busy), 32'd0);
            chk("rst_pixout", 32'(obs_pix), 32'h00);
            chk("rst_pixvalid", 32'(obs_valid), 32'd0);
        end

        // First edge with reset released accepts start; abort at CONVERT cycle 10.
        reset = 1'b1;
        step();
        start_a = 1'b0;
        run_phase(0, 5, 8'h00, -1);
        run_phase(1, 255, 8'h00, -1);
        run_phase(2, 255, 8'h00, 10);
        reset = 1'b0;
        step();
        chk("abort_strobes", 32'(obs_strb), 32'd0);
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_pixvalid", 32'(obs_valid), 32'd0);
        chk("abort_pixout", 32'(obs_pix), 32'h00);
        tb_en = 1'b1; tb_val = 8'h66; reset = 1'b1;
        step();
        chk("abort_bus_released", 32'(obs_data), 32'h66);
        chk("abort_pixvalid2", 32'(obs_valid), 32'd0);
        chk("abort_idle_busy", 32'(obs_busy), 32'd0);
        step();
        chk("abort_pixvalid3", 32'(obs_valid), 32'd0);
        chk("abort_pixout2", 32'(obs_pix), 32'h00);

        // Single default frame with a one-cycle start pulse.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_frame(8'hA5, 255);
        step();
        chk("hold_pixvalid", 32'(obs_valid), 32'd0);
        chk("hold_pixout", 32'(obs_pix), 32'hA5);
        chk("hold_idle", 32'(obs_strb), 32'd0);
        step();
        chk("hold_pixout2", 32'(obs_pix), 32'hA5);

        // Three back-to-back frames with start held high.
        start_a = 1'b1;
        step();
        run_frame(8'h5A, 255);
        step();
        run_frame(8'hC3, 255);
        step();
        start_a = 1'b0;
        run_frame(8'h96, 255);
        step();
        chk("b2b_stop_strobes", 32'(obs_strb), 32'd0);
        chk("b2b_stop_busy", 32'(obs_busy), 32'd0);
        chk("b2b_stop_pixout", 32'(obs_pix), 32'h96);

        // 256-cycle CONVERT: ramp ends at 8'h80 and releases the bus after.
        sel = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        run_frame(8'h7E, 256);
        chk("gray_last_code", 32'(gray8(255)), 32'h80);

        chk("bus_contention", 32'(contention), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
